// File: rtl/activation_lut_fetcher_pkg.sv
// Shared definitions for the activation LUT fetcher and its downstream interpolator.
// Holds the default geometry and the fetch-sequencer state encoding.
package activation_lut_fetcher_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int STEP_LOG2_DEF = 4;
    localparam int IDX_W_DEF     = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BASE  = 3'd1,
        RD_NEXT  = 3'd2,
        CAP_NEXT = 3'd3,
        OUT      = 3'd4
    } lut_state_t;

endpackage

// File: rtl/activation_lut_fetcher.sv
// Fetches the two bracketing table samples for an activation input z and
// presents them, with z and its aligned integer part, to the interpolator.
module activation_lut_fetcher
    import activation_lut_fetcher_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STEP_LOG2 = STEP_LOG2_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] z__value,
    input  logic              in__valid,
    output logic              in__ready,
    output logic [IDX_W-1:0]  tbl__addr,
    output logic              tbl__rd,
    input  logic [DATA_W-1:0] tbl__rdata,
    output logic [DATA_W-1:0] z__out,
    output logic [DATA_W-1:0] integer__part,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next__data,
    output logic              out__valid,
    input  logic              out__ready
);

    lut_state_t       state, state_next;
    logic [IDX_W-1:0] idx_in, idx_cur, idx_next;
    logic             frac_nz;

    // z__out doubles as the working copy of the accepted sample.
    assign idx_in   = IDX_W'(z__value[DATA_W-1:STEP_LOG2]);
    assign idx_cur  = IDX_W'(z__out[DATA_W-1:STEP_LOG2]);
    assign idx_next = (&idx_cur) ? idx_cur : idx_cur + IDX_W'(1);
    assign frac_nz  = |z__out[STEP_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in__ready  = 1'b0;
        case (state)
            IDLE: begin
                in__ready = 1'b1;
                if (in__valid) state_next = RD_BASE;
            end
            RD_BASE:  state_next = RD_NEXT;
            RD_NEXT:  state_next = frac_nz ? CAP_NEXT : OUT;
            CAP_NEXT: state_next = OUT;
            OUT:      if (out__ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Read strobe/address are registered one state ahead so they are
    // already asserted during the state that owns the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl__rd       <= 1'b0;
            tbl__addr     <= '0;
            z__out        <= '0;
            integer__part <= '0;
            base          <= '0;
            next__data    <= '0;
            out__valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in__valid) begin
                        z__out        <= z__value;
                        integer__part <= {z__value[DATA_W-1:STEP_LOG2], {STEP_LOG2{1'b0}}};
                        tbl__rd       <= 1'b1;
                        tbl__addr     <= idx_in;
                    end
                end
                RD_BASE: begin
                    tbl__rd <= frac_nz;
                    if (frac_nz) tbl__addr <= idx_next;
                end
                RD_NEXT: begin
                    base    <= tbl__rdata;
                    tbl__rd <= 1'b0;
                    if (!frac_nz) begin
                        // On-grid sample: no second read, both operands are the base word.
                        next__data <= tbl__rdata;
                        out__valid <= 1'b1;
                    end
                end
                CAP_NEXT: begin
                    next__data <= tbl__rdata;
                    out__valid <= 1'b1;
                end
                OUT: begin
                    if (out__ready) out__valid <= 1'b0;
                end
                default: begin
                    tbl__rd    <= 1'b0;
                    out__valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_lut_fetcher.sv
// Directed and randomized checks of the activation LUT fetcher against a
// table-lookup reference model.
module tb_activation_lut_fetcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] z__value;
    logic       in__valid;
    logic       in__ready;
    logic [3:0] tbl__addr;
    logic       tbl__rd;
    logic [7:0] tbl__rdata;
    logic [7:0] z__out, integer__part, base, next__data;
    logic       out__valid;
    logic       out__ready;

    int tests = 0;
    int fails = 0;
    logic [7:0] tbl_mem [16];
    logic [3:0] rd_q [$];

    always #5 clk = ~clk;

    activation_lut_fetcher dut (
        .clk(clk), .rst(rst), .z__value(z__value), .in__valid(in__valid),
        .in__ready(in__ready), .tbl__addr(tbl__addr), .tbl__rd(tbl__rd),
        .tbl__rdata(tbl__rdata), .z__out(z__out), .integer__part(integer__part),
        .base(base), .next__data(next__data), .out__valid(out__valid),
        .out__ready(out__ready)
    );

    // External table memory with one-cycle read latency, plus a log of reads.
    always @(posedge clk) begin
        if (tbl__rd) tbl__rdata <= tbl_mem[tbl__addr];
        if (!rst && tbl__rd) rd_q.push_back(tbl__addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [7:0] z, input int hold);
        int         n;
        int         lo, hi, exp_lat, exp_cnt;
        logic [7:0] exp_base, exp_next;
        lo       = int'(z) / 16;
        hi       = (lo == 15) ? 15 : lo + 1;
        exp_lat  = (z % 16 != 0) ? 4 : 3;
        exp_cnt  = (z % 16 != 0) ? 2 : 1;
        exp_base = tbl_mem[lo];
        exp_next = (z % 16 != 0) ? tbl_mem[hi] : tbl_mem[lo];
        rd_q.delete();
        @(negedge clk);
        chk("in_ready_idle", in__ready, 1);
        z__value  = z;
        in__valid = 1'b1;
        @(posedge clk);
        #1;
        in__valid = 1'b0;
        z__value  = 8'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out__valid) chk("in_ready_busy", in__ready, 0);
        end while (!out__valid && n < 10);
        chk("latency", n, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", out__valid, 1);
            chk("in_ready_out", in__ready, 0);
            chk("z_out", z__out, z);
            chk("integer_part", integer__part, z & 8'hF0);
            chk("base", base, exp_base);
            chk("next_data", next__data, exp_next);
            chk("rd_idle_out", tbl__rd, 0);
            chk("addr_hold", tbl__addr, (z % 16 != 0) ? hi : lo);
            if (h < hold) @(negedge clk);
        end
        out__ready = 1'b1;
        @(posedge clk);
        #1;
        out__ready = 1'b0;
        @(negedge clk);
        chk("out_valid_done", out__valid, 0);
        chk("in_ready_back", in__ready, 1);
        chk("rd_count", rd_q.size(), exp_cnt);
        if (rd_q.size() > 0) chk("rd_addr0", rd_q[0], lo);
        if (rd_q.size() > 1) chk("rd_addr1", rd_q[1], hi);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl_mem[i] = 8'(10 * i);
        rst        = 1'b1;
        z__value   = '0;
        in__valid  = 1'b0;
        out__ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out__valid, 0);
        chk("rst_tbl_rd", tbl__rd, 0);
        chk("rst_tbl_addr", tbl__addr, 0);
        chk("rst_z_out", z__out, 0);
        chk("rst_integer", integer__part, 0);
        chk("rst_base", base, 0);
        chk("rst_next", next__data, 0);
        chk("rst_in_ready", in__ready, 1);

        run_txn(8'h37, 0);
        run_txn(8'h50, 0);
        run_txn(8'hFA, 0);
        run_txn(8'h37, 3);
        run_txn(8'h00, 1);
        run_txn(8'hF0, 0);

        // Reset while the base word is being captured.
        @(negedge clk);
        z__value  = 8'h37;
        in__valid = 1'b1;
        @(posedge clk);
        #1;
        in__valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out__valid, 0);
        chk("midrst_tbl_rd", tbl__rd, 0);
        chk("midrst_in_ready", in__ready, 1);
        chk("midrst_base", base, 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_output", out__valid, 0);
        run_txn(8'h12, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) tbl_mem[i] = 8'($urandom);
            run_txn(8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
